// File: rtl/xbar_pkg.sv
// Shared constants for the 4x4 crossbar port arbiter: port geometry,
// destination-field position and sequencer state encodings.
package xbar_pkg;

  localparam int unsigned N_PORTS    = 4;
  localparam int unsigned PORT_IDX_W = 2;
  localparam int unsigned FLIT_W     = 15;

  localparam int unsigned DEST_MSB = FLIT_W - 1;
  localparam int unsigned DEST_LSB = FLIT_W - PORT_IDX_W;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARB  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic [PORT_IDX_W-1:0] next_idx(input logic [PORT_IDX_W-1:0] idx);
    return idx + PORT_IDX_W'(1);
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Rotating-priority picker: returns the first set request bit found when
// scanning upward from ptr, wrapping modulo four.
module rr_pick4
  import xbar_pkg::*;
(
  input  logic [N_PORTS-1:0]    req,
  input  logic [PORT_IDX_W-1:0] ptr,
  output logic                  found,
  output logic [PORT_IDX_W-1:0] winner
);

  logic [PORT_IDX_W-1:0] idx;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int unsigned k = 0; k < N_PORTS; k++) begin
      idx = ptr + PORT_IDX_W'(k);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/xbar_port_arbiter.sv
// Batch sequencer for the 4x4 crossbar: latches up to four flits on start,
// then delivers them to their destination outputs under per-output round-robin.
module xbar_port_arbiter #(
  parameter int unsigned FLIT_W  = xbar_pkg::FLIT_W,
  parameter logic [1:0]  RR_INIT = 2'd0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        ivalid,
  input  logic [FLIT_W-1:0] iport0,
  input  logic [FLIT_W-1:0] iport1,
  input  logic [FLIT_W-1:0] iport2,
  input  logic [FLIT_W-1:0] iport3,
  output logic [FLIT_W-1:0] oport0,
  output logic [FLIT_W-1:0] oport1,
  output logic [FLIT_W-1:0] oport2,
  output logic [FLIT_W-1:0] oport3,
  output logic [3:0]        ovalid,
  output logic [3:0]        grant,
  output logic              busy,
  output logic              done
);
  import xbar_pkg::*;

  // Destination field always occupies the top bits, whatever the flit width.
  localparam int unsigned DST_HI = FLIT_W - (xbar_pkg::FLIT_W - DEST_MSB);
  localparam int unsigned DST_LO = FLIT_W - (xbar_pkg::FLIT_W - DEST_LSB);

  logic [1:0]            state;
  logic [FLIT_W-1:0]     flit_q  [N_PORTS];
  logic [FLIT_W-1:0]     oport_q [N_PORTS];
  logic [PORT_IDX_W-1:0] rr_ptr  [N_PORTS];
  logic [N_PORTS-1:0]    pending;
  logic [N_PORTS-1:0]    pending_nxt;
  logic [N_PORTS-1:0]    win_mask;
  logic [N_PORTS-1:0]    req     [N_PORTS];
  logic [N_PORTS-1:0]    found;
  logic [PORT_IDX_W-1:0] winner  [N_PORTS];

  assign oport0 = oport_q[0];
  assign oport1 = oport_q[1];
  assign oport2 = oport_q[2];
  assign oport3 = oport_q[3];

  always_comb begin
    for (int unsigned o = 0; o < N_PORTS; o++) begin
      req[o] = '0;
      for (int unsigned i = 0; i < N_PORTS; i++) begin
        req[o][i] = pending[i] && (flit_q[i][DST_HI:DST_LO] == PORT_IDX_W'(o));
      end
    end
  end

  for (genvar o = 0; o < N_PORTS; o++) begin : g_pick
    rr_pick4 u_pick (
      .req    (req[o]),
      .ptr    (rr_ptr[o]),
      .found  (found[o]),
      .winner (winner[o])
    );
  end

  // Each pending input targets exactly one output, so winners never collide.
  always_comb begin
    win_mask = '0;
    for (int unsigned o = 0; o < N_PORTS; o++) begin
      if (found[o]) begin
        win_mask[winner[o]] = 1'b1;
      end
    end
    pending_nxt = pending & ~win_mask;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      pending <= '0;
      ovalid  <= '0;
      grant   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      for (int unsigned o = 0; o < N_PORTS; o++) begin
        flit_q[o]  <= '0;
        oport_q[o] <= '0;
        rr_ptr[o]  <= RR_INIT;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          ovalid <= '0;
          grant  <= '0;
          done   <= 1'b0;
          if (start) begin
            flit_q[0] <= iport0;
            flit_q[1] <= iport1;
            flit_q[2] <= iport2;
            flit_q[3] <= iport3;
            pending   <= ivalid;
            busy      <= 1'b1;
            state     <= ST_ARB;
          end
        end
        ST_ARB: begin
          for (int unsigned o = 0; o < N_PORTS; o++) begin
            ovalid[o] <= found[o];
            if (found[o]) begin
              oport_q[o] <= flit_q[winner[o]];
              rr_ptr[o]  <= next_idx(winner[o]);
            end
          end
          grant   <= win_mask;
          pending <= pending_nxt;
          if (pending_nxt == '0) begin
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          ovalid <= '0;
          grant  <= '0;
          done   <= 1'b0;
          busy   <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          ovalid  <= '0;
          grant   <= '0;
          done    <= 1'b0;
          busy    <= 1'b0;
          pending <= '0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xbar_port_arbiter.sv
// Self-checking bench for xbar_port_arbiter against a batch-level
// round-robin delivery model.
module tb_xbar_port_arbiter;

  localparam int unsigned FW = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [3:0]    ivalid;
  logic [FW-1:0] iport0, iport1, iport2, iport3;
  logic [FW-1:0] oport0, oport1, oport2, oport3;
  logic [3:0]    ovalid, grant;
  logic          busy, done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  xbar_port_arbiter #(.FLIT_W(FW), .RR_INIT(2'd0)) dut (
    .clk(clk), .rst(rst), .start(start), .ivalid(ivalid),
    .iport0(iport0), .iport1(iport1), .iport2(iport2), .iport3(iport3),
    .oport0(oport0), .oport1(oport1), .oport2(oport2), .oport3(oport3),
    .ovalid(ovalid), .grant(grant), .busy(busy), .done(done)
  );

  // Reference model: which inputs still wait, where each output's scan starts,
  // and the last flit each output presented.
  int                  m_rr [4];
  logic [3:0]          m_pend;
  logic [3:0][FW-1:0]  m_flit;
  logic [FW-1:0]       m_out [4];

  function automatic logic [FW-1:0] rnd_flit(input int d);
    logic [1:0] dd;
    dd = 2'(d);
    return {dd, 13'($urandom)};
  endfunction

  task automatic model_reset();
    for (int o = 0; o < 4; o++) begin
      m_rr[o]  = 0;
      m_out[o] = '0;
    end
    m_pend = '0;
  endtask

  task automatic model_cycle(output logic [3:0] eov, output logic [3:0] egr);
    eov = '0;
    egr = '0;
    for (int o = 0; o < 4; o++) begin
      int base;
      base = m_rr[o];
      for (int k = 0; k < 4; k++) begin
        int i;
        i = (base + k) % 4;
        if (!eov[o] && m_pend[i] && (m_flit[i][FW-1 -: 2] == 2'(o))) begin
          eov[o]   = 1'b1;
          egr[i]   = 1'b1;
          m_out[o] = m_flit[i];
          m_rr[o]  = (i + 1) % 4;
        end
      end
    end
    m_pend = m_pend & ~egr;
  endtask

  function automatic logic [69:0] obs();
    return {oport3, oport2, oport1, oport0, ovalid, grant, busy, done};
  endfunction

  function automatic logic [69:0] expv(input logic [3:0] ov, input logic [3:0] gr,
                                       input logic b, input logic d);
    return {m_out[3], m_out[2], m_out[1], m_out[0], ov, gr, b, d};
  endfunction

  task automatic apply_reset();
    rst = 1'b0; start = 1'b0; ivalid = '0;
    iport0 = '0; iport1 = '0; iport2 = '0; iport3 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  // Presents a batch for one edge, then scrambles the inputs so nothing relies on them being held.
  task automatic launch(input logic [3:0] v, input logic [3:0][FW-1:0] f);
    @(negedge clk);
    start = 1'b1; ivalid = v;
    iport0 = f[0]; iport1 = f[1]; iport2 = f[2]; iport3 = f[3];
    m_pend = v;
    m_flit = f;
    @(posedge clk); #1;
    start  = 1'b0;
    ivalid = 4'($urandom);
    iport0 = FW'($urandom); iport1 = FW'($urandom);
    iport2 = FW'($urandom); iport3 = FW'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b1; ivalid = 4'hF;
    iport0 = '1; iport1 = '1; iport2 = '1; iport3 = '1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs() !== 70'd0) begin
      failures++; $display("FAIL reset_hold: got %h want %h", obs(), 70'd0);
    end
    start = 1'b0;
    @(negedge clk); rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    checks++;
    if (obs() !== 70'd0) begin
      failures++; $display("FAIL reset_release: got %h want %h", obs(), 70'd0);
    end
  endtask

  task automatic test_identity();
    logic [3:0][FW-1:0] f;
    logic [3:0] eov, egr;
    for (int i = 0; i < 4; i++) f[i] = rnd_flit(i);
    launch(4'hF, f);
    checks++;
    if (obs() !== expv(4'h0, 4'h0, 1'b1, 1'b0)) begin
      failures++; $display("FAIL ident_arb: got %h want %h", obs(), expv(4'h0, 4'h0, 1'b1, 1'b0));
    end
    @(posedge clk); #1;
    model_cycle(eov, egr);
    checks++;
    if ({ovalid, grant, done, oport3, oport2, oport1, oport0} !== {4'hF, 4'hF, 1'b1, f[3], f[2], f[1], f[0]}) begin
      failures++;
      $display("FAIL ident_deliver: got ov=%h gr=%h done=%b o=%h %h %h %h want ov=f gr=f done=1 o=%h %h %h %h",
               ovalid, grant, done, oport3, oport2, oport1, oport0, f[3], f[2], f[1], f[0]);
    end
    checks++;
    if (obs() !== expv(eov, egr, 1'b1, m_pend == 0)) begin
      failures++; $display("FAIL ident_model: got %h want %h", obs(), expv(eov, egr, 1'b1, m_pend == 0));
    end
    @(posedge clk); #1;
    checks++;
    if (obs() !== expv(4'h0, 4'h0, 1'b0, 1'b0)) begin
      failures++; $display("FAIL ident_idle: got %h want %h", obs(), expv(4'h0, 4'h0, 1'b0, 1'b0));
    end
  endtask

  task automatic test_same_dest();
    logic [3:0][FW-1:0] f;
    logic [3:0] eov, egr;
    apply_reset();
    for (int i = 0; i < 4; i++) f[i] = rnd_flit(2);
    launch(4'hF, f);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      model_cycle(eov, egr);
      checks++;
      if ({ovalid, grant, oport2, done} !== {4'b0100, 4'(1 << k), f[k], k == 3}) begin
        failures++;
        $display("FAIL same_dest_%0d: got ov=%h gr=%h o2=%h done=%b want ov=4 gr=%h o2=%h done=%b",
                 k, ovalid, grant, oport2, done, 4'(1 << k), f[k], k == 3);
      end
    end
    checks++;
    if (obs() !== expv(eov, egr, 1'b1, 1'b1)) begin
      failures++; $display("FAIL same_dest_model: got %h want %h", obs(), expv(eov, egr, 1'b1, 1'b1));
    end
    @(posedge clk); #1;
    checks++;
    if (obs() !== expv(4'h0, 4'h0, 1'b0, 1'b0)) begin
      failures++; $display("FAIL same_dest_idle: got %h want %h", obs(), expv(4'h0, 4'h0, 1'b0, 1'b0));
    end
  endtask

  // Each row: mask to output 2 and the grant order implied by the pointer left behind by the row before.
  task automatic test_rr_pointer();
    logic [3:0] masks [4];
    int         seq   [4][2];
    int         cnt   [4];
    logic [3:0][FW-1:0] f;
    logic [3:0] eov, egr;
    masks[0] = 4'b1010; seq[0][0] = 1; seq[0][1] = 3; cnt[0] = 2;
    masks[1] = 4'b0100; seq[1][0] = 2; seq[1][1] = 0; cnt[1] = 1;
    masks[2] = 4'b1100; seq[2][0] = 3; seq[2][1] = 2; cnt[2] = 2;
    masks[3] = 4'b1001; seq[3][0] = 3; seq[3][1] = 0; cnt[3] = 2;
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 4; i++) f[i] = rnd_flit(2);
      launch(masks[b], f);
      for (int k = 0; k < cnt[b]; k++) begin
        @(posedge clk); #1;
        model_cycle(eov, egr);
        checks++;
        if ({ovalid, grant, oport2, done} !== {4'b0100, 4'(1 << seq[b][k]), f[seq[b][k]], k == cnt[b] - 1}) begin
          failures++;
          $display("FAIL rr_b%0d_%0d: got ov=%h gr=%h o2=%h done=%b want ov=4 gr=%h o2=%h done=%b",
                   b, k, ovalid, grant, oport2, done, 4'(1 << seq[b][k]), f[seq[b][k]], k == cnt[b] - 1);
        end
      end
      @(posedge clk); #1;
      checks++;
      if (obs() !== expv(4'h0, 4'h0, 1'b0, 1'b0)) begin
        failures++; $display("FAIL rr_b%0d_idle: got %h want %h", b, obs(), expv(4'h0, 4'h0, 1'b0, 1'b0));
      end
    end
  endtask

  task automatic test_empty();
    logic [3:0][FW-1:0] f;
    for (int i = 0; i < 4; i++) f[i] = rnd_flit($urandom_range(0, 3));
    launch(4'h0, f);
    checks++;
    if ({busy, done, ovalid, grant} !== {1'b1, 1'b0, 8'h00}) begin
      failures++; $display("FAIL empty_arb: got b=%b d=%b ov=%h gr=%h want b=1 d=0 ov=0 gr=0", busy, done, ovalid, grant);
    end
    @(posedge clk); #1;
    checks++;
    if (obs() !== expv(4'h0, 4'h0, 1'b1, 1'b1)) begin
      failures++; $display("FAIL empty_done: got %h want %h", obs(), expv(4'h0, 4'h0, 1'b1, 1'b1));
    end
    @(posedge clk); #1;
    checks++;
    if (obs() !== expv(4'h0, 4'h0, 1'b0, 1'b0)) begin
      failures++; $display("FAIL empty_idle: got %h want %h", obs(), expv(4'h0, 4'h0, 1'b0, 1'b0));
    end
  endtask

  task automatic test_start_ignored();
    logic [3:0][FW-1:0] f;
    logic [3:0] eov, egr;
    logic fin;
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 4; i++) f[i] = rnd_flit($urandom_range(0, 3));
      f[1] = {f[0][FW-1 -: 2], f[1][FW-3:0]};
      launch(4'b0011 | 4'($urandom), f);
      fin = 1'b0;
      for (int c = 0; c < 6 && !fin; c++) begin
        @(posedge clk); #1;
        start = (c == 0);
        ivalid = 4'hF;
        iport0 = rnd_flit(b); iport1 = rnd_flit(b); iport2 = rnd_flit(b); iport3 = rnd_flit(b);
        model_cycle(eov, egr);
        fin = (m_pend == 0);
        checks++;
        if (obs() !== expv(eov, egr, 1'b1, fin)) begin
          failures++; $display("FAIL ignore_b%0d_c%0d: got %h want %h", b, c, obs(), expv(eov, egr, 1'b1, fin));
        end
      end
      start = 1'b0;
      repeat (2) begin
        @(posedge clk); #1;
        checks++;
        if (obs() !== expv(4'h0, 4'h0, 1'b0, 1'b0)) begin
          failures++; $display("FAIL ignore_b%0d_idle: got %h want %h", b, obs(), expv(4'h0, 4'h0, 1'b0, 1'b0));
        end
      end
    end
  endtask

  task automatic test_random();
    logic [3:0][FW-1:0] f;
    logic [3:0] eov, egr;
    logic fin;
    for (int b = 0; b < 24; b++) begin
      for (int i = 0; i < 4; i++) f[i] = rnd_flit($urandom_range(0, 3));
      launch(4'($urandom), f);
      checks++;
      if (obs() !== expv(4'h0, 4'h0, 1'b1, 1'b0)) begin
        failures++; $display("FAIL rand_b%0d_entry: got %h want %h", b, obs(), expv(4'h0, 4'h0, 1'b1, 1'b0));
      end
      fin = 1'b0;
      for (int c = 0; c < 6 && !fin; c++) begin
        @(posedge clk); #1;
        model_cycle(eov, egr);
        fin = (m_pend == 0);
        checks++;
        if (obs() !== expv(eov, egr, 1'b1, fin)) begin
          failures++; $display("FAIL rand_b%0d_c%0d: got %h want %h", b, c, obs(), expv(eov, egr, 1'b1, fin));
        end
      end
      @(posedge clk); #1;
      checks++;
      if (obs() !== expv(4'h0, 4'h0, 1'b0, 1'b0)) begin
        failures++; $display("FAIL rand_b%0d_idle: got %h want %h", b, obs(), expv(4'h0, 4'h0, 1'b0, 1'b0));
      end
    end
  endtask

  task automatic test_reset_mid_batch();
    logic [3:0][FW-1:0] f;
    logic [3:0] eov, egr;
    for (int i = 0; i < 4; i++) f[i] = rnd_flit(1);
    launch(4'b0111, f);
    @(posedge clk); #1;
    model_cycle(eov, egr);
    checks++;
    if (obs() !== expv(eov, egr, 1'b1, 1'b0)) begin
      failures++; $display("FAIL midrst_first: got %h want %h", obs(), expv(eov, egr, 1'b1, 1'b0));
    end
    #2 rst = 1'b0;
    #1;
    model_reset();
    checks++;
    if (obs() !== 70'd0) begin
      failures++; $display("FAIL midrst_clear: got %h want %h", obs(), 70'd0);
    end
    @(posedge clk); #1;
    checks++;
    if (obs() !== 70'd0) begin
      failures++; $display("FAIL midrst_nodone: got %h want %h", obs(), 70'd0);
    end
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 4; i++) f[i] = rnd_flit(1);
    launch(4'hF, f);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      model_cycle(eov, egr);
      checks++;
      if ({ovalid, grant, oport1, done} !== {4'b0010, 4'(1 << k), f[k], k == 3}) begin
        failures++;
        $display("FAIL midrst_new_%0d: got ov=%h gr=%h o1=%h done=%b want ov=2 gr=%h o1=%h done=%b",
                 k, ovalid, grant, oport1, done, 4'(1 << k), f[k], k == 3);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (obs() !== expv(4'h0, 4'h0, 1'b0, 1'b0)) begin
      failures++; $display("FAIL midrst_idle: got %h want %h", obs(), expv(4'h0, 4'h0, 1'b0, 1'b0));
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; ivalid = '0;
    iport0 = '0; iport1 = '0; iport2 = '0; iport3 = '0;
    model_reset();
    test_reset();
    test_identity();
    test_same_dest();
    test_rr_pointer();
    test_empty();
    test_start_ignored();
    test_random();
    test_reset_mid_batch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/xbar_port_arbiter.md
Name: xbar_port_arbiter

Overview:
- Sequencer/arbiter for the 4x4 crossbar switch: it latches one batch of up to four 15-bit flits, one per input port, on a start strobe.
- Each flit's destination field selects an output port. Contention for an output is resolved with a per-output round-robin pointer.
- Each output carries at most one flit per cycle; a done pulse marks the end of the batch.
- Sits between the input memory controller/ROM and the result checker, replacing the fixed input-to-output mapping.

Parameters:
- FLIT_W, 15, flit width; bits [FLIT_W-1:FLIT_W-2] are the destination port and the rest is payload.
- RR_INIT, 0, reset value (0..3) of every output's round-robin pointer.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin batch; sampled only in IDLE
- ivalid  in  4  per-input flit-present mask, sampled with start
- iport0..iport3  in  FLIT_W each  input flits, sampled with start
- oport0..oport3  out  FLIT_W each  flit delivered to each output
- ovalid  out  4  bit o=1: oport o carries a new flit this cycle
- grant  out  4  bit i=1: input i's flit delivered this cycle (one pulse per flit)
- busy  out  1  high in ARB and DONE
- done  out  1  one-cycle end-of-batch pulse

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; pending=0; flit registers=0.
  - oport*=0, ovalid=0, grant=0, busy=0, done=0.
  - All rr_ptr[o]=RR_INIT.
  - Reset mid-batch discards the batch with no done pulse.
- States: IDLE, ARB, DONE.
- IDLE:
  - When start=1 at an edge: latch iport0..3 into flit regs, pending<=ivalid, go to ARB.
  - Input ports need not be held after that edge.
- ARB (one arbitration round per cycle):
  - dest(i) = flit_i[FLIT_W-1:FLIT_W-2].
  - For each output o, the candidates are pending inputs with dest(i)==o.
  - Winner = first candidate searching rr_ptr[o], rr_ptr[o]+1, ... mod 4.
  - At the edge, for each output with a winner w:
    - oport o <= flit_w, ovalid[o] <= 1, grant[w] <= 1.
    - Clear pending[w].
    - rr_ptr[o] <= (w+1) mod 4.
  - Outputs without a winner: ovalid[o] <= 0, oport o holds its last value, rr_ptr[o] unchanged.
  - Up to 4 grants per cycle when destinations are distinct.
  - Next pending==0 -> DONE, otherwise stay in ARB.
  - ARB always lasts at least one cycle.
- DONE:
  - done=1 for exactly one cycle; the last grant's ovalid/grant are visible in this same cycle.
  - At the next edge, ovalid=0, grant=0 and state returns to IDLE.
- Latency:
  - start sampled at edge T; first grants visible after edge T+2.
  - Batch with k flits all to one output: ovalid pulses at T+2..T+k+1, done at T+k+1.
- start while busy: ignored, no effect.
- Empty batch (ivalid=0): ARB for one cycle, then done at T+2; no ovalid or grant.
- Pointers persist across batches; they are cleared only by reset.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package (xbar_pkg):
  - N_PORTS=4, PORT_IDX_W=2, FLIT_W=15.
  - Destination-field MSB/LSB constants.
  - State encoding constants IDLE/ARB/DONE.
- One natural sub-module, rr_pick4, instantiated once per output:
  - Inputs: 4-bit request mask and 2-bit pointer.
  - Outputs: found flag and 2-bit winner index.
  - Purely combinational rotate-priority-encode.

Test Plan:
- Reset, then start with ivalid=4'b1111 and destinations 0,1,2,3 (identity) -> at T+2 ovalid=4'b1111, grant=4'b1111, oportN=iportN, done=1; back to IDLE at T+3.
- All four flits with dest=2, pointers at reset (RR_INIT=0) -> oport2 delivers inputs 0,1,2,3 at T+2..T+5, one per cycle; done at T+5; rr_ptr[2]=0 afterwards.
- Repeat the previous batch using only inputs 2 and 3 to dest 2, with rr_ptr[2]=3 -> input 3 is granted first, then input 2; rr_ptr[2]=3 afterwards.
- Start with ivalid=4'b0000 -> done at T+2; ovalid and grant stay 0; busy high during T+1..T+2.
- Start pulsed again during ARB with different flits -> ignored; delivered data matches the first batch only.
- rst driven low while ARB has 2 flits pending -> outputs and pending clear immediately with no done pulse; after rst=1, a new batch runs normally from RR_INIT.
